rr_request_arbiter: RTL
=======================

// Module: rr_request_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream resource among 16 requesters.
//  Built around the 16-bit highest-bit-first priority encoding used by the project's encoder datapath.
//  On reset, priority is strictly highest-index-first. After each grant, priority rotates below the last winner.
//  Grants are held until the owner signals done, drops its request, or exceeds a hold limit.
// PARAMETERS
//  N_REQ     16  number of requesters (fixed at 16 for this revision)
//  IDX_W     4   width of grant index, $clog2(N_REQ)
//  MAX_HOLD  15  max cycles a grant may be held before forced release (1..2^CNT_W-1)
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      synchronous reset, active low
//  ena           in   1      arbitration enable; low blocks new grants only
//  req           in   16     request vector, bit i = requester i
//  done          in   1      current owner finished; releases grant
//  grant_valid   out  1      a grant is active
//  grant_idx     out  4      index of current owner (valid when grant_valid)
//  grant_onehot  out  16     one-hot of grant_idx, all-zero when !grant_valid
//  timeout       out  1      one-cycle pulse: grant was force-released
//  busy          out  1      FSM in GRANT state (== grant_valid)
// BEHAVIOUR
//  - One clock, sync active-low reset. All state updates on posedge clk.
//  - Reset (rst_n=0 at edge): state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0,
//    timeout=0, hold_cnt=0, last_idx=0. Any grant in progress is dropped immediately.
//  - FSM states: IDLE, GRANT.
//  - IDLE:
//    - If ena && |req, compute winner combinationally.
//      - masked = req & ((1<<last_idx)-1), i.e. bits strictly below last_idx.
//      - If masked != 0, winner = highest set bit of masked; else winner = highest set bit of req.
//    - Next edge: GRANT, grant_valid=1, grant_idx=winner, last_idx=winner, hold_cnt=1.
//    - Latency from req sampled to grant_valid = 1 cycle.
//    - If !ena or req==0: stay IDLE, outputs 0.
//  - GRANT (per edge, priority order):
//    1. done=1 -> IDLE, grant_valid=0, timeout=0. done wins over timeout on the same cycle.
//    2. req[grant_idx]=0 -> IDLE, no timeout (requester withdrew).
//    3. hold_cnt==MAX_HOLD -> IDLE, timeout=1 for exactly one cycle.
//    4. Otherwise hold_cnt++ and grant is held; grant_idx is stable throughout.
//  - ena=0 during GRANT does not release the grant.
//  - After any release, one IDLE cycle always occurs before the next grant.
//  - grant_valid is never high for more than MAX_HOLD consecutive cycles.
//  - Requests from non-owners during GRANT are ignored (not queued). They are re-evaluated in IDLE.
//  - timeout is high only in the first IDLE cycle following a forced release; otherwise 0.
//  - last_idx is updated only on grant; it is not cleared on release.
//  - All outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  - Shared package/include (arb_defs):
//    - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1
//    - N_REQ, IDX_W, CNT_W=$clog2(MAX_HOLD+1)
//  - Sub-module prio_enc16: 16-bit highest-set-bit encoder, outputs idx[3:0] and any.
//    Instantiated twice, once on masked and once on raw req.
//  - Top holds the FSM, hold counter, last_idx register, mask generation and one-hot decode.
// TESTING
//  - Reset: drive rst_n=0 with req=16'hFFFF, done=0.
//    -> grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0 while in reset and the cycle after release.
//  - First grant: after reset, ena=1, req=16'h0120.
//    -> 1 cycle later grant_valid=1, grant_idx=8, grant_onehot=16'h0100.
//  - Rotation: req=16'h8001 held, done pulsed each grant cycle.
//    -> grant_idx sequence 15, 0, 15, 0 with one idle cycle between each grant.
//  - Timeout: req=16'h0004 held, done=0, MAX_HOLD=15.
//    -> grant_valid high exactly 15 cycles, then timeout=1 for 1 cycle.
//    -> Grant to idx 2 again after that idle cycle.
//  - Release and enable: while owner idx 5 holds the grant, drop req[5]
//    -> next cycle grant_valid=0, timeout=0. Then set ena=0 with req=16'hFFFF -> no grant until ena=1.
//  - Reset mid-grant: rst_n=0 while grant_idx=9 with hold_cnt=7.
//    -> next edge all outputs 0. After reset, req=16'h0200 -> grant_idx=9 again (last_idx cleared).

Source files
------------

// File: rtl/rr_request_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the 16-way round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_request_arbiter_pkg;

    localparam int N_REQ    = 16;
    localparam int IDX_W    = $clog2(N_REQ);
    localparam int MAX_HOLD = 15;
    localparam int CNT_W    = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Bits strictly below idx; idx 0 yields an empty mask so the raw encoder wins.
    function automatic req_vec_t below_mask(idx_t idx);
        return (req_vec_t'(1) << idx) - req_vec_t'(1);
    endfunction

endpackage

// File: rtl/rr_request_arbiter_if.sv
// Request/grant bundle between the requester pool and the arbiter.
// Latency: wires only.
// Backpressure: none; owners keep the grant by holding req and release with done.
interface rr_request_arbiter_if;
    import rr_request_arbiter_pkg::*;

    logic     ena;
    req_vec_t req;
    logic     done;
    logic     grant_valid;
    idx_t     grant_idx;
    req_vec_t grant_onehot;
    logic     timeout;
    logic     busy;

    modport master (
        output ena, req, done,
        input  grant_valid, grant_idx, grant_onehot, timeout, busy
    );

    modport slave (
        input  ena, req, done,
        output grant_valid, grant_idx, grant_onehot, timeout, busy
    );

endinterface

// File: rtl/rr_request_arbiter_prio_enc16.sv
// 16-bit highest-set-bit priority encoder.
// Latency: combinational.
// Backpressure: n/a; idx is 0 when no bit is set.
module rr_request_arbiter_prio_enc16
    import rr_request_arbiter_pkg::*;
(
    input  req_vec_t vec,
    output idx_t     idx,
    output logic     any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Ascending scan: the last hit, i.e. the highest set bit, wins.
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter granting one of 16 requesters, rotating priority below the last winner.
// Latency: 1 cycle req->grant; one idle cycle after every release; all outputs registered.
// Backpressure: ena low blocks new grants only; grant ends on done, req drop or MAX_HOLD.
module rr_request_arbiter
    import rr_request_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rr_request_arbiter_if.slave  arb
);

    arb_state_e state_q,        state_d;
    idx_t       grant_idx_q,    grant_idx_d;
    req_vec_t   grant_onehot_q, grant_onehot_d;
    logic       timeout_q,      timeout_d;
    cnt_t       hold_cnt_q,     hold_cnt_d;
    idx_t       last_idx_q,     last_idx_d;

    req_vec_t masked_req;
    idx_t     masked_idx;
    idx_t     raw_idx;
    logic     masked_any;
    logic     raw_any;
    idx_t     winner;

    assign masked_req = arb.req & below_mask(last_idx_q);

    rr_request_arbiter_prio_enc16 u_enc_masked (
        .vec (masked_req),
        .idx (masked_idx),
        .any (masked_any)
    );

    rr_request_arbiter_prio_enc16 u_enc_raw (
        .vec (arb.req),
        .idx (raw_idx),
        .any (raw_any)
    );

    assign winner = masked_any ? masked_idx : raw_idx;

    always_comb begin
        state_d        = state_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        timeout_d      = 1'b0;
        hold_cnt_d     = hold_cnt_q;
        last_idx_d     = last_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb.ena && raw_any) begin
                    state_d        = ST_GRANT;
                    grant_idx_d    = winner;
                    grant_onehot_d = req_vec_t'(1) << winner;
                    last_idx_d     = winner;
                    hold_cnt_d     = cnt_t'(1);
                end
            end
            ST_GRANT: begin
                // done outranks withdrawal, which outranks the hold limit.
                if (arb.done || !arb.req[grant_idx_q] || (hold_cnt_q == cnt_t'(MAX_HOLD))) begin
                    state_d        = ST_IDLE;
                    grant_idx_d    = '0;
                    grant_onehot_d = '0;
                    hold_cnt_d     = '0;
                    timeout_d      = !arb.done && arb.req[grant_idx_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            timeout_q      <= 1'b0;
            hold_cnt_q     <= '0;
            last_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            timeout_q      <= timeout_d;
            hold_cnt_q     <= hold_cnt_d;
            last_idx_q     <= last_idx_d;
        end
    end

    assign arb.grant_valid  = (state_q == ST_GRANT);
    assign arb.busy         = (state_q == ST_GRANT);
    assign arb.grant_idx    = grant_idx_q;
    assign arb.grant_onehot = grant_onehot_q;
    assign arb.timeout      = timeout_q;

endmodule
